alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (minimum 2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: A  input  WIDTH  first operand, unsigned bit-vector, two's-complement for overflow.
REQ-005 Port: B  input  WIDTH  second operand, same encoding as A.
REQ-006 Port: ALUOp  input  2  operation select.
REQ-007 Port: C  output  WIDTH  registered result.
REQ-008 Port (only with ALU_FLAGS_EN): Zero  output  1  registered; C equals all zeros.
REQ-009 Port (only with ALU_FLAGS_EN): Carry  output  1  registered; add carry-out or subtract borrow.
REQ-010 Port (only with ALU_FLAGS_EN): Overflow  output  1  registered; signed overflow of add or subtract.

Function
REQ-011 ALUOp 2'b00 SHALL compute A + B, modulo 2^WIDTH.
REQ-012 ALUOp 2'b01 SHALL compute A - B, modulo 2^WIDTH.
REQ-013 ALUOp 2'b10 SHALL compute bitwise A & B.
REQ-014 ALUOp 2'b11 SHALL compute bitwise A | B.
REQ-015 The result SHALL be captured into C on every rising clk edge while reset is low, giving exactly one cycle of latency.
REQ-016 There is no handshake and no enable: inputs are sampled every cycle, and C reflects the inputs present at the previous edge.
REQ-017 Carry SHALL be the carry-out of bit WIDTH-1 for add, and 1 when B > A (unsigned borrow) for subtract.
REQ-018 Overflow SHALL be set for add when A and B have the same sign and the sum's sign differs, and for subtract when the signs of A and B differ and the result's sign differs from A.
REQ-019 For logic ops (10, 11), Carry and Overflow SHALL be 0.
REQ-020 Zero SHALL be computed from the same result value that is registered into C.
REQ-021 Operands and ALUOp changing every cycle SHALL produce a correct result every cycle, with no stall or bubble.

Reset
REQ-022 While reset is high at a rising clk edge, C SHALL load 0 and all flags SHALL load 0 (Zero also 0), regardless of inputs.
REQ-023 The first valid result SHALL appear on the edge after the first edge with reset low; reset mid-stream discards the in-flight result.

Configuration
REQ-024 Macro ALU_FLAGS_EN defined: the Zero, Carry and Overflow ports and their registers SHALL exist.
REQ-025 Macro ALU_FLAGS_EN undefined: those ports and their logic SHALL be absent, and C behaviour SHALL be identical.

Structure
REQ-026 Shared package alu_pkg SHALL hold the ALUOp encodings (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11) and the default width constant.
REQ-027 A sub-module alu_addsub SHALL implement the shared adder/subtractor (B inverted plus carry-in for subtract) and produce sum, carry and overflow.
REQ-028 alu SHALL contain the operation mux, flag logic and output registers.

Verification
REQ-029 Reset high for 2 cycles with A=4'b1001, B=4'b0001 -> C=4'b0000 and all flags 0.
REQ-030 ADD: A=4'b1001, B=4'b0001 -> C=4'b1010 one cycle later; A=4'b0111, B=4'b1010 -> C=4'b0001, Carry=1.
REQ-031 SUB: A=4'b1111, B=4'b0011 -> C=4'b1100; A=4'b1000, B=4'b0101 -> C=4'b0011, Overflow=1.
REQ-032 AND: A=4'b1000, B=4'b0101 -> C=4'b0000, Zero=1; A=4'b1110, B=4'b0111 -> C=4'b0110.
REQ-033 OR: A=4'b1110, B=4'b0111 -> C=4'b1111; A=4'b1001, B=4'b0010 -> C=4'b1011.
REQ-034 Back-to-back op changes every cycle, with reset asserted in the middle -> each result appears exactly one cycle later, and the cycle after reset shows 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, default width and an op-class helper.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    // Add and subtract are the only ops that produce Carry/Overflow.
    function automatic logic is_arith(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: subtract is A + ~B + 1. Carry output is already in flag
// form (carry-out for add, unsigned borrow for subtract).
module alu_addsub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    assign full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum  = full[WIDTH-1:0];

    // A subtract produces carry-out 1 when no borrow occurred, so invert it.
    assign carry    = full[WIDTH] ^ sub;
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered ALU (add, sub, and, or) with one cycle of latency.
// Define ALU_FLAGS_EN to add the registered Zero, Carry and Overflow outputs.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUOp,
    output logic [WIDTH-1:0] C
`ifdef ALU_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow
`endif
);

    alu_op_e          op;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;
    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] c_reg;

    assign op = alu_op_e'(ALUOp);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (A),
        .b        (B),
        .sub      (op == ALU_SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_overflow)
    );

    always_comb begin
        result_next = '0;
        unique case (op)
            ALU_ADD,
            ALU_SUB: result_next = as_sum;
            ALU_AND: result_next = A & B;
            ALU_OR:  result_next = A | B;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_reg <= '0;
        end else begin
            c_reg <= result_next;
        end
    end

    assign C = c_reg;

`ifdef ALU_FLAGS_EN
    logic zero_reg;
    logic carry_reg;
    logic overflow_reg;

    // Zero is cleared on reset even though C is then all zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            zero_reg     <= (result_next == '0);
            carry_reg    <= is_arith(op) ? as_carry : 1'b0;
            overflow_reg <= is_arith(op) ? as_overflow : 1'b0;
        end
    end

    assign Zero     = zero_reg;
    assign Carry    = carry_reg;
    assign Overflow = overflow_reg;
`else
    logic unused_flags;
    assign unused_flags = as_carry ^ as_overflow;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes modelled results, monitor pops and compares.
// Flag checks are active when ALU_FLAGS_EN is defined.
module tb_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   ALUOp;
    logic [W-1:0] C;
`ifdef ALU_FLAGS_EN
    logic         Zero;
    logic         Carry;
    logic         Overflow;
`endif

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .ALUOp    (ALUOp),
        .C        (C)
`ifdef ALU_FLAGS_EN
        ,
        .Zero     (Zero),
        .Carry    (Carry),
        .Overflow (Overflow)
`endif
    );

    typedef struct {
        logic [W-1:0] c;
        logic         z;
        logic         cy;
        logic         ov;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   failures  = 0;

    // Reference model from arithmetic on integers rather than bit-level logic.
    function automatic exp_t model(input int a, input int b, input int op,
                                   input bit rst, input string nm);
        exp_t e;
        int m    = 1 << W;
        int half = m / 2;
        int sa   = (a >= half) ? a - m : a;
        int sb   = (b >= half) ? b - m : b;
        int r    = 0;
        int s    = 0;
        e.name = nm;
        e.cy   = 1'b0;
        e.ov   = 1'b0;
        if (rst) begin
            e.c = '0;
            e.z = 1'b0;
            return e;
        end
        case (op)
            0: begin
                r    = a + b;
                e.cy = (r >= m);
                r    = r % m;
                s    = sa + sb;
                e.ov = (s < -half) || (s > half - 1);
            end
            1: begin
                r    = a - b;
                e.cy = (b > a);
                if (r < 0) r = r + m;
                s    = sa - sb;
                e.ov = (s < -half) || (s > half - 1);
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        e.c = r[W-1:0];
        e.z = (r == 0);
        return e;
    endfunction

    task automatic drive(input int a, input int b, input int op,
                         input bit rst, input string nm);
        @(negedge clk);
        reset = rst;
        A     = a[W-1:0];
        B     = b[W-1:0];
        ALUOp = op[1:0];
        sb_q.push_back(model(a, b, op, rst, nm));
    endtask

    // Monitor: one result per rising edge, sampled just after it.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests_run++;
                bad = (C !== e.c);
`ifdef ALU_FLAGS_EN
                bad = bad || (Zero !== e.z) || (Carry !== e.cy) || (Overflow !== e.ov);
                if (bad) begin
                    failures++;
                    $display("FAIL %s: got C=%b Z=%b Cy=%b Ov=%b, expected C=%b Z=%b Cy=%b Ov=%b",
                             e.name, C, Zero, Carry, Overflow, e.c, e.z, e.cy, e.ov);
                end else begin
                    $display("ok   %s: C=%b Z=%b Cy=%b Ov=%b", e.name, C, Zero, Carry, Overflow);
                end
`else
                if (bad) begin
                    failures++;
                    $display("FAIL %s: got C=%b, expected C=%b", e.name, C, e.c);
                end else begin
                    $display("ok   %s: C=%b", e.name, C);
                end
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d results still queued", sb_q.size());
        failures++;
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        A     = '0;
        B     = '0;
        ALUOp = '0;

        // Reset held for two cycles with live operands.
        drive(4'b1001, 4'b0001, 0, 1'b1, "reset_0");
        drive(4'b1001, 4'b0001, 0, 1'b1, "reset_1");
        // Directed vectors.
        drive(4'b1001, 4'b0001, 0, 1'b0, "add_9_1");
        drive(4'b0111, 4'b1010, 0, 1'b0, "add_carry");
        drive(4'b1111, 4'b0011, 1, 1'b0, "sub_15_3");
        drive(4'b1000, 4'b0101, 1, 1'b0, "sub_ovf");
        drive(4'b1000, 4'b0101, 2, 1'b0, "and_zero");
        drive(4'b1110, 4'b0111, 2, 1'b0, "and_14_7");
        drive(4'b1110, 4'b0111, 3, 1'b0, "or_14_7");
        drive(4'b1001, 4'b0010, 3, 1'b0, "or_9_2");
        // Boundaries: wrap to zero, borrow, signed overflow both directions.
        drive(4'b1111, 4'b0001, 0, 1'b0, "add_wrap");
        drive(4'b0000, 4'b0001, 1, 1'b0, "sub_borrow");
        drive(4'b0111, 4'b0001, 0, 1'b0, "add_pos_ovf");
        drive(4'b0101, 4'b0101, 1, 1'b0, "sub_equal");
        drive(4'b0000, 4'b0000, 3, 1'b0, "or_zero");
        // Back-to-back op changes with reset in the middle.
        drive(4'b0011, 4'b0100, 0, 1'b0, "b2b_add");
        drive(4'b0010, 4'b0101, 1, 1'b0, "b2b_sub");
        drive(4'b1111, 4'b1111, 3, 1'b1, "b2b_reset");
        drive(4'b0001, 4'b0010, 3, 1'b0, "b2b_or");
        drive(4'b1111, 4'b1111, 2, 1'b0, "b2b_and");

        for (int i = 0; i < 200; i++) begin
            drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                  $sformatf("rand_%0d", i));
        end

        @(posedge clk);
        #2;
        tests_run++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results left in scoreboard, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
